n64_demux_ctrl: RTL and testbench
=================================

N64_DEMUX_CTRL -- requirements
Module: n64_demux_ctrl

Interface
REQ-001 SHALL have parameter color_width, default 7, meaning video data bus width.
REQ-002 SHALL have parameter PAL_THRESH, default 280, meaning lines per field above which the mode is PAL.
REQ-003 SHALL have parameter HYST_FRAMES, default 3, meaning consecutive agreeing fields needed to change auto-deblur.
REQ-004 SHALL have port VCLK, input, 1, the only clock, rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port nDSYNC, input, 1, low marks the sync word slot.
REQ-007 SHALL have port D_i, input, color_width, video data: in sync slots [3]=nVSYNC, [2]=nCLAMP, [1]=nHSYNC, [0]=nCSYNC.
REQ-008 SHALL have port deblurmode_i, input, 2, deblur mode: 00 auto, 01 force on, 1x force off.
REQ-009 SHALL have port n16bit_i, input, 1, high selects 21-bit colour and low selects 16-bit colour.
REQ-010 SHALL have port demuxparams_o, output, 5, {data_cnt[1:0], vmode, ndo_deblur, n16bit_mode}.
REQ-011 SHALL have port interlaced_o, output, 1, high for interlaced source.

Function
REQ-012 data_cnt SHALL load 2'b01 on every VCLK edge with nDSYNC low; otherwise it SHALL increment, wrapping 11->00.
REQ-013 A sync word SHALL be the D_i value sampled with nDSYNC low; edges SHALL be detected against the previous sync word only.
REQ-014 The line counter (9 bit, saturating at 511) SHALL increment on each falling nHSYNC and clear on falling nVSYNC.
REQ-015 On falling nVSYNC, vmode SHALL become 1 if the line count exceeds PAL_THRESH, else 0.
REQ-016 On falling nVSYNC, interlaced_o SHALL become 1 if the line count differs from the previous field's count, else 0.
REQ-017 A pixel SHALL be formed from D_i captured at data_cnt 01/10/11 (R/G/B) and SHALL complete at the next nDSYNC-low slot.
REQ-018 Pixel parity SHALL reset to even on falling nHSYNC and toggle per completed pixel.
REQ-019 On each completed odd pixel while nCSYNC is high, the block SHALL compare its RGB with the preceding even pixel and increment eq_cnt or diff_cnt (12 bit each, saturating).
REQ-020 On falling nVSYNC, the field vote SHALL be "320" if eq_cnt != 0 and diff_cnt < (eq_cnt >> 4), else "640"; both counters SHALL then clear.
REQ-021 The auto decision SHALL change only after HYST_FRAMES consecutive votes that disagree with the current decision; an agreeing vote SHALL clear the disagreement run counter.
REQ-022 ndo_deblur SHALL be 0 iff deblurmode_i==01, or deblurmode_i==00 and auto decision is "320" and interlaced_o==0; otherwise it SHALL be 1.
REQ-023 n16bit_mode SHALL be n16bit_i registered through two VCLK flops.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-025 When falling nHSYNC and falling nVSYNC occur in the same sync word, the vertical update SHALL use the pre-increment count and the counter SHALL clear.
REQ-026 When deblurmode_i changes mid-field, ndo_deblur SHALL follow within 1 VCLK; the auto state SHALL be unaffected.

Reset
REQ-027 While RST is high: data_cnt=00, vmode=0, ndo_deblur=1, n16bit_mode=1, interlaced_o=0, and all counters and the auto decision ("640") SHALL be cleared.
REQ-028 Reset asserted mid-field SHALL discard partial counts; the first field after release SHALL produce no vmode or interlace update before its first falling nVSYNC.

Structure
REQ-029 color_width, sync bit indices, demuxparams field offsets and deblur-mode encodings SHALL live in the shared n64rgb params header.
REQ-030 The pixel-pair comparator with eq/diff counters SHALL be one sub-module, n64_deblur_detect; line counting and the FSM SHALL stay in the top module.

Verification
REQ-031 Sync slot, then 3 data slots, repeated -> data_cnt sequence 01,10,11 every pixel; stretched high nDSYNC -> 00 then 01 at next sync.
REQ-032 Field of 262 lines then 312 lines -> vmode 0 then 1, each updated exactly at the falling nVSYNC slot.
REQ-033 Alternating 262/263-line fields -> interlaced_o=1 and ndo_deblur=1 despite the auto vote being "320".
REQ-034 Auto mode, duplicated pixel pairs -> ndo_deblur falls only after the 3rd such field; one "640" field between them resets the run count.
REQ-035 deblurmode_i=01 and 10 -> ndo_deblur 0 and 1 respectively within 1 VCLK.
REQ-036 Assert RST mid-line -> all outputs at their reset values (demuxparams_o=5'b00011) immediately, asynchronously.

Source files
------------

// File: rtl/n64_demux_ctrl_pkg.sv
// rtl/n64_demux_ctrl_pkg.sv - shared n64rgb parameters, encodings and deblur decision helper
package n64_demux_ctrl_pkg;

    localparam int COLOR_WIDTH = 7;

    localparam int SYNC_NVSYNC = 3;
    localparam int SYNC_NHSYNC = 1;
    localparam int SYNC_NCSYNC = 0;

    localparam int DP_N16BIT   = 0;
    localparam int DP_NDEBLUR  = 1;
    localparam int DP_VMODE    = 2;
    localparam int DP_DATA_CNT = 3;

    typedef enum logic [1:0] {
        DEBLUR_AUTO      = 2'b00,
        DEBLUR_FORCE_ON  = 2'b01,
        DEBLUR_FORCE_OFF = 2'b10
    } deblur_mode_e;

    typedef enum logic {
        DEC_640 = 1'b0,
        DEC_320 = 1'b1
    } auto_dec_e;

    // Mode 11 decodes as force off together with 10.
    function automatic logic ndo_deblur_f(input logic [1:0] mode, input logic dec_320,
                                          input logic interlaced);
        if (mode == DEBLUR_FORCE_ON)
            return 1'b0;
        if (mode == DEBLUR_AUTO)
            return !(dec_320 && !interlaced);
        return 1'b1;
    endfunction

endpackage

// File: rtl/n64_demux_ctrl_if.sv
// rtl/n64_demux_ctrl_if.sv - N64 multiplexed video bus (sync strobe plus data word)
interface n64_demux_ctrl_if #(
    parameter int color_width = n64_demux_ctrl_pkg::COLOR_WIDTH
);
    logic                   nDSYNC;
    logic [color_width-1:0] D_i;

    modport master (output nDSYNC, output D_i);
    modport slave  (input  nDSYNC, input  D_i);
endinterface

// File: rtl/n64_demux_ctrl_deblur_detect.sv
// rtl/n64_demux_ctrl_deblur_detect.sv - pixel-pair comparator counting equal/different pairs per field
module n64_deblur_detect
    import n64_demux_ctrl_pkg::*;
#(
    parameter int color_width = COLOR_WIDTH
) (
    input  logic                   VCLK,
    input  logic                   RST,
    input  logic                   nDSYNC,
    input  logic [color_width-1:0] D_i,
    input  logic [1:0]             data_cnt,
    input  logic                   ncsync,
    input  logic                   nhsync_fall,
    input  logic                   nvsync_fall,
    output logic                   vote_320
);
    logic [color_width-1:0]   r_q, g_q, b_q;
    logic [3*color_width-1:0] even_q;
    logic                     pix_valid_q;
    logic                     odd_q;
    logic [11:0]              eq_cnt_q, diff_cnt_q;
    logic                     pix_done;
    logic                     cmp_en;

    assign pix_done = !nDSYNC && pix_valid_q;
    assign cmp_en   = pix_done && odd_q && ncsync;

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            even_q      <= '0;
            pix_valid_q <= 1'b0;
            odd_q       <= 1'b0;
            eq_cnt_q    <= '0;
            diff_cnt_q  <= '0;
        end else begin
            if (nDSYNC) begin
                case (data_cnt)
                    2'b01: r_q <= D_i;
                    2'b10: g_q <= D_i;
                    2'b11: begin
                        b_q         <= D_i;
                        pix_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                pix_valid_q <= 1'b0;
            end

            if (pix_done && !odd_q)
                even_q <= {r_q, g_q, b_q};

            if (nhsync_fall)
                odd_q <= 1'b0;
            else if (pix_done)
                odd_q <= ~odd_q;

            // Field boundary wins over a pair completing in the same slot.
            if (nvsync_fall) begin
                eq_cnt_q   <= '0;
                diff_cnt_q <= '0;
            end else if (cmp_en) begin
                if ({r_q, g_q, b_q} == even_q) begin
                    if (eq_cnt_q != 12'hFFF)
                        eq_cnt_q <= eq_cnt_q + 12'd1;
                end else begin
                    if (diff_cnt_q != 12'hFFF)
                        diff_cnt_q <= diff_cnt_q + 12'd1;
                end
            end
        end
    end

    assign vote_320 = (eq_cnt_q != 12'd0) && (diff_cnt_q < (eq_cnt_q >> 4));

endmodule

// File: rtl/n64_demux_ctrl.sv
// rtl/n64_demux_ctrl.sv - N64 video demux control: slot counter, line/field timing, deblur decision
module n64_demux_ctrl
    import n64_demux_ctrl_pkg::*;
#(
    parameter int color_width = COLOR_WIDTH,
    parameter int PAL_THRESH  = 280,
    parameter int HYST_FRAMES = 3
) (
    input  logic                  VCLK,
    input  logic                  RST,
    n64_demux_ctrl_if.slave       vbus,
    input  logic [1:0]            deblurmode_i,
    input  logic                  n16bit_i,
    output logic [4:0]            demuxparams_o,
    output logic                  interlaced_o
);
    localparam int         RUN_W = (HYST_FRAMES > 1) ? $clog2(HYST_FRAMES) : 1;
    localparam logic [8:0] PAL_T = 9'(PAL_THRESH);

    logic [1:0]       data_cnt_q;
    logic             vs_q, hs_q, cs_q;
    logic [8:0]       line_cnt_q, prev_cnt_q;
    logic             vmode_q, interlaced_q, interlaced_d;
    logic             ndo_deblur_q;
    logic [1:0]       n16_pipe_q;
    auto_dec_e        dec_q, dec_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             sync_slot, nvsync_fall, nhsync_fall, vote_320;

    assign sync_slot   = !vbus.nDSYNC;
    assign nvsync_fall = sync_slot && vs_q && !vbus.D_i[SYNC_NVSYNC];
    assign nhsync_fall = sync_slot && hs_q && !vbus.D_i[SYNC_NHSYNC];

    n64_deblur_detect #(.color_width(color_width)) u_detect (
        .VCLK        (VCLK),
        .RST         (RST),
        .nDSYNC      (vbus.nDSYNC),
        .D_i         (vbus.D_i),
        .data_cnt    (data_cnt_q),
        .ncsync      (cs_q),
        .nhsync_fall (nhsync_fall),
        .nvsync_fall (nvsync_fall),
        .vote_320    (vote_320)
    );

    // Auto-deblur hysteresis: flip only after a full run of disagreeing field votes.
    always_comb begin
        dec_d = dec_q;
        run_d = run_q;
        if (nvsync_fall) begin
            if (vote_320 == (dec_q == DEC_320)) begin
                run_d = '0;
            end else if (run_q == RUN_W'(HYST_FRAMES - 1)) begin
                dec_d = vote_320 ? DEC_320 : DEC_640;
                run_d = '0;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    assign interlaced_d = nvsync_fall ? (line_cnt_q != prev_cnt_q) : interlaced_q;

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            data_cnt_q   <= 2'b00;
            vs_q         <= 1'b1;
            hs_q         <= 1'b1;
            cs_q         <= 1'b1;
            line_cnt_q   <= '0;
            prev_cnt_q   <= '0;
            vmode_q      <= 1'b0;
            interlaced_q <= 1'b0;
            ndo_deblur_q <= 1'b1;
            n16_pipe_q   <= 2'b11;
            dec_q        <= DEC_640;
            run_q        <= '0;
        end else begin
            data_cnt_q <= sync_slot ? 2'b01 : data_cnt_q + 2'b01;
            if (sync_slot) begin
                vs_q <= vbus.D_i[SYNC_NVSYNC];
                hs_q <= vbus.D_i[SYNC_NHSYNC];
                cs_q <= vbus.D_i[SYNC_NCSYNC];
            end
            // Vertical update sees the pre-increment count; clearing wins over a coincident hsync.
            if (nvsync_fall) begin
                vmode_q    <= (line_cnt_q > PAL_T);
                prev_cnt_q <= line_cnt_q;
                line_cnt_q <= '0;
            end else if (nhsync_fall && line_cnt_q != 9'h1FF) begin
                line_cnt_q <= line_cnt_q + 9'd1;
            end
            interlaced_q <= interlaced_d;
            dec_q        <= dec_d;
            run_q        <= run_d;
            ndo_deblur_q <= ndo_deblur_f(deblurmode_i, dec_d == DEC_320, interlaced_d);
            n16_pipe_q   <= {n16_pipe_q[0], n16bit_i};
        end
    end

    always_comb begin
        demuxparams_o                     = '0;
        demuxparams_o[DP_DATA_CNT +: 2]   = data_cnt_q;
        demuxparams_o[DP_VMODE]           = vmode_q;
        demuxparams_o[DP_NDEBLUR]         = ndo_deblur_q;
        demuxparams_o[DP_N16BIT]          = n16_pipe_q[1];
    end

    assign interlaced_o = interlaced_q;

endmodule

// File: tb/tb_n64_demux_ctrl.sv
// tb/tb_n64_demux_ctrl.sv - randomized self-checking bench with field-level reference model
module tb_n64_demux_ctrl;
    logic       VCLK = 1'b0;
    logic       RST  = 1'b1;
    logic [1:0] deblurmode_i = 2'b00;
    logic       n16bit_i = 1'b1;
    logic [4:0] demuxparams_o;
    logic       interlaced_o;
    bit         rand_ctl = 1'b0;
    int         checks = 0;
    int         errors = 0;

    n64_demux_ctrl_if #(.color_width(7)) vbus ();

    n64_demux_ctrl #(.color_width(7), .PAL_THRESH(280), .HYST_FRAMES(3)) dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .vbus          (vbus),
        .deblurmode_i  (deblurmode_i),
        .n16bit_i      (n16bit_i),
        .demuxparams_o (demuxparams_o),
        .interlaced_o  (interlaced_o)
    );

    always #5 VCLK = ~VCLK;

    // Reference model state, expressed as counts and pixel values.
    int m_cnt, m_lines, m_prev, m_npix, m_even, m_eq, m_diff, m_run;
    int m_rgb[3];
    bit m_vs, m_hs, m_cs, m_vmode, m_inter, m_have, m_dec320, m_ndo, m_n16a, m_n16b;

    task automatic model_reset();
        m_cnt = 0; m_lines = 0; m_prev = 0; m_npix = 0; m_even = 0;
        m_eq = 0; m_diff = 0; m_run = 0;
        m_rgb[0] = 0; m_rgb[1] = 0; m_rgb[2] = 0;
        m_vs = 1; m_hs = 1; m_cs = 1; m_vmode = 0; m_inter = 0; m_have = 0;
        m_dec320 = 0; m_ndo = 1; m_n16a = 1; m_n16b = 1;
    endtask

    task automatic model_edge(input bit nds, input logic [6:0] d, input logic [1:0] mode, input bit n16);
        bit vf, hf, done, vote320;
        int pix;
        if (RST) begin
            model_reset();
            return;
        end
        vf   = !nds && m_vs && !d[3];
        hf   = !nds && m_hs && !d[1];
        done = !nds && m_have;
        pix  = (m_rgb[0] << 14) | (m_rgb[1] << 7) | m_rgb[2];
        if (vf) begin
            vote320 = (m_eq != 0) && (m_diff < m_eq / 16);
            m_vmode = (m_lines > 280);
            m_inter = (m_lines != m_prev);
            m_prev  = m_lines;
            m_lines = 0;
            if (vote320 == m_dec320) m_run = 0;
            else begin
                m_run++;
                if (m_run >= 3) begin m_dec320 = vote320; m_run = 0; end
            end
            m_eq = 0; m_diff = 0;
        end else begin
            if (hf && m_lines < 511) m_lines++;
            if (done && (m_npix % 2 == 1) && m_cs) begin
                if (pix == m_even) begin if (m_eq < 4095) m_eq++; end
                else begin if (m_diff < 4095) m_diff++; end
            end
        end
        if (done && (m_npix % 2 == 0)) m_even = pix;
        if (hf) m_npix = 0;
        else if (done) m_npix++;
        if (nds) begin
            if (m_cnt >= 1) m_rgb[m_cnt - 1] = int'(d);
            if (m_cnt == 3) m_have = 1;
            m_cnt = (m_cnt + 1) % 4;
        end else begin
            m_have = 0; m_cnt = 1;
            m_vs = d[3]; m_hs = d[1]; m_cs = d[0];
        end
        if (mode == 2'b01) m_ndo = 0;
        else if (mode == 2'b00) m_ndo = !(m_dec320 && !m_inter);
        else m_ndo = 1;
        m_n16b = m_n16a;
        m_n16a = n16;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge VCLK) begin
        check("demuxparams", 32'(demuxparams_o), 32'({2'(m_cnt), m_vmode, m_ndo, m_n16b}));
        check("interlaced", 32'(interlaced_o), 32'(m_inter));
    end

    task automatic tick(input bit nds, input logic [6:0] d);
        vbus.nDSYNC = nds;
        vbus.D_i    = d;
        @(posedge VCLK);
        model_edge(nds, d, deblurmode_i, n16bit_i);
        #1;
        if (rand_ctl) begin
            if ($urandom_range(299) == 0) deblurmode_i = 2'($urandom);
            if ($urandom_range(99) == 0) n16bit_i = ~n16bit_i;
        end
    endtask

    task automatic pixel(input bit vs, input bit hs, input logic [20:0] rgb, input bit stretch);
        logic [6:0] w;
        w    = 7'($urandom);
        w[3] = vs;
        w[1] = hs;
        w[0] = hs ? ($urandom_range(7) != 0) : 1'b0;
        tick(1'b0, w);
        tick(1'b1, rgb[20:14]);
        tick(1'b1, rgb[13:7]);
        tick(1'b1, rgb[6:0]);
        if (stretch) tick(1'b1, 7'($urandom));
    endtask

    task automatic field(input int nlines, input int npix, input bit dup);
        logic [20:0] ev, px;
        ev = '0;
        for (int l = 0; l < nlines; l++) begin
            for (int i = 0; i < npix; i++) begin
                if (i % 2 == 0) begin ev = 21'($urandom); px = ev; end
                else px = dup ? ev : (ev ^ 21'h1);
                pixel(!(l < 3), i != 0, px, $urandom_range(15) == 0);
            end
        end
    endtask

    initial begin
        vbus.nDSYNC = 1'b1;
        vbus.D_i    = '0;
        model_reset();
        repeat (3) @(posedge VCLK);
        #1;
        check("reset_demuxparams", 32'(demuxparams_o), 32'h03);
        check("reset_interlaced", 32'(interlaced_o), 32'h0);
        RST = 1'b0;

        // Slot counter: sync, three data slots, next sync.
        tick(1'b0, 7'h7F); check("cnt_sync", 32'(demuxparams_o[4:3]), 32'h1);
        tick(1'b1, 7'h11); check("cnt_r", 32'(demuxparams_o[4:3]), 32'h2);
        tick(1'b1, 7'h22); check("cnt_g", 32'(demuxparams_o[4:3]), 32'h3);
        tick(1'b1, 7'h33); check("cnt_stretch", 32'(demuxparams_o[4:3]), 32'h0);
        tick(1'b0, 7'h7F); check("cnt_resync", 32'(demuxparams_o[4:3]), 32'h1);

        // Auto hysteresis, one 640 field breaks the run.
        field(30, 4, 0);
        field(30, 4, 1); check("hy_inter_first", 32'(interlaced_o), 32'h1);
        field(30, 4, 1); check("hy_inter_equal", 32'(interlaced_o), 32'h0);
        field(30, 4, 0);
        field(30, 4, 1);
        field(30, 4, 1); check("hy_run_reset", 32'(demuxparams_o[1]), 32'h1);
        field(30, 4, 1); check("hy_two_votes", 32'(demuxparams_o[1]), 32'h1);
        field(30, 4, 1); check("hy_third_vote", 32'(demuxparams_o[1]), 32'h0);

        // NTSC then PAL line counts.
        field(262, 2, 1);
        field(312, 2, 1); check("vmode_ntsc", 32'(demuxparams_o[2]), 32'h0);
        field(20, 4, 1);  check("vmode_pal", 32'(demuxparams_o[2]), 32'h1);

        // Alternating field lengths mark interlace and block deblur.
        field(262, 2, 1);
        field(263, 2, 1);
        field(262, 2, 1); check("il_inter_a", 32'(interlaced_o), 32'h1);
        field(263, 2, 1); check("il_inter_b", 32'(interlaced_o), 32'h1);
        check("il_ndeblur", 32'(demuxparams_o[1]), 32'h1);
        check("il_vmode", 32'(demuxparams_o[2]), 32'h0);

        deblurmode_i = 2'b01; tick(1'b1, 7'h00); check("force_on", 32'(demuxparams_o[1]), 32'h0);
        deblurmode_i = 2'b10; tick(1'b1, 7'h00); check("force_off", 32'(demuxparams_o[1]), 32'h1);
        deblurmode_i = 2'b11; tick(1'b1, 7'h00); check("force_off_11", 32'(demuxparams_o[1]), 32'h1);
        deblurmode_i = 2'b00;
        n16bit_i = 1'b0;
        tick(1'b1, 7'h00); check("n16_stage1", 32'(demuxparams_o[0]), 32'h1);
        tick(1'b1, 7'h00); check("n16_stage2", 32'(demuxparams_o[0]), 32'h0);

        rand_ctl = 1'b1;
        for (int f = 0; f < 10; f++)
            field($urandom_range(40, 8), 2 * $urandom_range(3, 1), $urandom_range(1));
        rand_ctl = 1'b0;

        // Asynchronous reset in the middle of a line.
        tick(1'b0, 7'h7F);
        tick(1'b1, 7'h15);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check("arst_demuxparams", 32'(demuxparams_o), 32'h03);
        check("arst_interlaced", 32'(interlaced_o), 32'h0);
        tick(1'b1, 7'h00);
        tick(1'b0, 7'h7F);
        RST = 1'b0;
        deblurmode_i = 2'b00;
        n16bit_i = 1'b1;
        for (int f = 0; f < 4; f++)
            field(25, 4, 1);
        check("post_rst_inter", 32'(interlaced_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
